// File: rtl/i2c_passthru_pkg.sv
// Shared definitions for the I2C passthru bit receiver/transmitter pair.
package i2c_passthru_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        RISE,
        HIGH,
        END
    } state_e;

    // Defaults assume a 4 MHz f_ref: 20 edges = 5.0 us low/high, 2 edges = 0.5 us data setup
    localparam int F_REF_T_LOW_DEF          = 20;
    localparam int WIDTH_F_REF_T_LOW_DEF    = 5;
    localparam int F_REF_T_SU_DAT_DEF       = 2;
    localparam int WIDTH_F_REF_T_SU_DAT_DEF = 2;

endpackage

// File: rtl/i2c_passthru_bittx_if.sv
// Bit-transmitter bundle: f_ref timing, bitrx status, far-side bus lines and results.
interface i2c_passthru_bittx_if;
    logic i_f_ref;
    logic i_start_tx;
    logic i_tx_is_to_mst;
    logic i_rx_sda_init_valid;
    logic i_rx_sda_init;
    logic i_rx_sda_mid_change;
    logic i_rx_sda_final;
    logic i_rx_done;
    logic i_scl;
    logic i_sda;
    logic o_scl;
    logic o_sda;
    logic o_tx_done;
    logic o_violation;

    modport slave (
        input  i_f_ref, i_start_tx, i_tx_is_to_mst, i_rx_sda_init_valid, i_rx_sda_init,
               i_rx_sda_mid_change, i_rx_sda_final, i_rx_done, i_scl, i_sda,
        output o_scl, o_sda, o_tx_done, o_violation
    );

    modport master (
        output i_f_ref, i_start_tx, i_tx_is_to_mst, i_rx_sda_init_valid, i_rx_sda_init,
               i_rx_sda_mid_change, i_rx_sda_final, i_rx_done, i_scl, i_sda,
        input  o_scl, o_sda, o_tx_done, o_violation
    );
endinterface

// File: rtl/i2c_passthru_fref_cnt.sv
// f_ref rising-edge detector feeding a saturating counter with synchronous clear.
module i2c_passthru_fref_cnt #(
    parameter int WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_f_ref,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt
);
    logic             f_ref_q;
    logic             rise_w;
    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign rise_w = i_f_ref & ~f_ref_q;
    assign o_cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr)
            cnt_d = '0;
        else if (i_en && rise_w && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            f_ref_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            f_ref_q <= i_f_ref;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/i2c_passthru_bittx.sv
// Drives one I2C bit onto the far-side bus, either as clock-stretching slave
// (toward the master) or as SCL-generating master (toward the slave).
module i2c_passthru_bittx
    import i2c_passthru_pkg::*;
#(
    parameter int F_REF_T_LOW          = F_REF_T_LOW_DEF,
    parameter int WIDTH_F_REF_T_LOW    = WIDTH_F_REF_T_LOW_DEF,
    parameter int F_REF_T_SU_DAT       = F_REF_T_SU_DAT_DEF,
    parameter int WIDTH_F_REF_T_SU_DAT = WIDTH_F_REF_T_SU_DAT_DEF
) (
    input logic                 i_clk,
    input logic                 i_rst,
    i2c_passthru_bittx_if.slave bus
);
    localparam logic [WIDTH_F_REF_T_LOW-1:0]    LOW_EXIT  = WIDTH_F_REF_T_LOW'(F_REF_T_LOW - 1);
    localparam logic [WIDTH_F_REF_T_LOW-1:0]    HIGH_EXIT = WIDTH_F_REF_T_LOW'(F_REF_T_LOW);
    localparam logic [WIDTH_F_REF_T_SU_DAT-1:0] SU_EXIT   = WIDTH_F_REF_T_SU_DAT'(F_REF_T_SU_DAT);

    state_e state_q, state_d;
    logic   scl_q, scl_d, sda_q, sda_d;
    logic   done_q, done_d, viol_q, viol_d;
    logic   mst_q, mst_d, seen_q, seen_d;
    logic   sda_low_q, sda_low_d;
    logic   clr_low, en_low, clr_su, en_su;
    logic [WIDTH_F_REF_T_LOW-1:0]    cnt_low;
    logic [WIDTH_F_REF_T_SU_DAT-1:0] cnt_su;

    i2c_passthru_fref_cnt #(.WIDTH(WIDTH_F_REF_T_LOW)) u_cnt_low (
        .i_clk(i_clk), .i_rst(i_rst), .i_f_ref(bus.i_f_ref),
        .i_clr(clr_low), .i_en(en_low), .o_cnt(cnt_low)
    );

    i2c_passthru_fref_cnt #(.WIDTH(WIDTH_F_REF_T_SU_DAT)) u_cnt_su (
        .i_clk(i_clk), .i_rst(i_rst), .i_f_ref(bus.i_f_ref),
        .i_clr(clr_su), .i_en(en_su), .o_cnt(cnt_su)
    );

    // Setup time is measured from the o_sda update, so it only runs once data was seen
    assign en_su = (state_q == LOW) && seen_q;

    always_comb begin
        state_d   = state_q;
        scl_d     = scl_q;
        sda_d     = sda_q;
        done_d    = done_q;
        viol_d    = viol_q;
        mst_d     = mst_q;
        seen_d    = seen_q;
        sda_low_d = 1'b0;
        clr_low   = 1'b0;
        en_low    = 1'b0;
        clr_su    = ~seen_q;
        if (bus.i_start_tx) begin
            state_d = LOW;
            scl_d   = 1'b0;
            sda_d   = 1'b1;
            done_d  = 1'b0;
            viol_d  = 1'b0;
            mst_d   = bus.i_tx_is_to_mst;
            seen_d  = 1'b0;
            clr_low = 1'b1;
            clr_su  = 1'b1;
        end else begin
            case (state_q)
                LOW: begin
                    en_low = 1'b1;
                    scl_d  = 1'b0;
                    if (!seen_q && bus.i_rx_sda_init_valid) begin
                        sda_d  = bus.i_rx_sda_init;
                        seen_d = 1'b1;
                    end
                    if (seen_q && (cnt_low >= LOW_EXIT) && (cnt_su >= SU_EXIT)) begin
                        state_d = RISE;
                        scl_d   = 1'b1;
                    end
                end
                RISE: begin
                    if (bus.i_scl) begin
                        clr_low = 1'b1;
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    en_low = 1'b1;
                    if (bus.i_rx_sda_mid_change)
                        sda_d = bus.i_rx_sda_final;
                    if (mst_q) begin
                        // Someone else pulling SDA while we release it, debounced over two clocks
                        sda_low_d = !bus.i_sda && sda_q;
                        if (sda_low_d && sda_low_q)
                            viol_d = 1'b1;
                        if (!bus.i_scl) begin
                            scl_d   = 1'b0;
                            state_d = END;
                        end
                    end else if (cnt_low >= HIGH_EXIT) begin
                        scl_d   = 1'b0;
                        state_d = END;
                    end
                end
                END: begin
                    scl_d = 1'b0;
                    if (bus.i_rx_done) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            done_q    <= 1'b0;
            viol_q    <= 1'b0;
            mst_q     <= 1'b0;
            seen_q    <= 1'b0;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            done_q    <= done_d;
            viol_q    <= viol_d;
            mst_q     <= mst_d;
            seen_q    <= seen_d;
            sda_low_q <= sda_low_d;
        end
    end

    assign bus.o_scl       = scl_q;
    assign bus.o_sda       = sda_q;
    assign bus.o_tx_done   = done_q;
    assign bus.o_violation = viol_q;
endmodule

// File: tb/tb_i2c_passthru_bittx.sv
// Directed bench for i2c_passthru_bittx: 100 MHz clock, 4 MHz f_ref (25 clocks per period).
module tb_i2c_passthru_bittx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    i2c_passthru_bittx_if bus ();

    i2c_passthru_bittx dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial begin
        bus.i_f_ref = 1'b0;
        forever begin
            repeat (13) @(negedge clk);
            bus.i_f_ref = 1'b1;
            repeat (12) @(negedge clk);
            bus.i_f_ref = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_bit(input logic to_mst);
        bus.i_tx_is_to_mst = to_mst;
        bus.i_start_tx     = 1'b1;
        tick();
        bus.i_start_tx     = 1'b0;
    endtask

    task automatic wait_scl(input logic val, input int budget);
        int c;
        c = 0;
        while (bus.o_scl !== val && c < budget) begin
            tick();
            c++;
        end
    endtask

    initial begin
        int   cyc, bad, edges;
        logic prev, early, seen, viol_any, sda_hi;

        bus.i_start_tx          = 1'b0;
        bus.i_tx_is_to_mst      = 1'b0;
        bus.i_rx_sda_init_valid = 1'b0;
        bus.i_rx_sda_init       = 1'b1;
        bus.i_rx_sda_mid_change = 1'b0;
        bus.i_rx_sda_final      = 1'b1;
        bus.i_rx_done           = 1'b0;
        bus.i_scl               = 1'b1;
        bus.i_sda               = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", bus.o_scl, 1'b1);
        chk("rst_sda", bus.o_sda, 1'b1);
        chk("rst_done", bus.o_tx_done, 1'b0);
        chk("rst_viol", bus.o_violation, 1'b0);
        rst = 1'b0;
        tick();

        // Bit 1: to master, data 1 valid early
        bus.i_rx_sda_init_valid = 1'b1;
        bus.i_rx_sda_init       = 1'b1;
        bus.i_rx_done           = 1'b1;
        bus.i_scl               = 1'b0;
        start_bit(1'b1);
        chk("t1_scl_low_1clk", bus.o_scl, 1'b0);
        chk("t1_sda_1clk", bus.o_sda, 1'b1);
        cyc = 1;
        bad = 0;
        while (bus.o_scl !== 1'b1 && cyc < 600) begin
            if (bus.o_tx_done !== 1'b0 || bus.o_sda !== 1'b1) bad++;
            tick();
            cyc++;
        end
        chk("t1_low_clean", bad == 0, 1'b1);
        chk("t1_no_rise_before_4us", cyc > 400, 1'b1);
        chk("t1_rise_by_6us", bus.o_scl, 1'b1);
        bus.i_scl = 1'b1;
        bad = 0;
        viol_any = 1'b0;
        repeat (400) begin
            tick();
            if (bus.o_scl !== 1'b1) bad++;
            viol_any |= bus.o_violation;
        end
        chk("t1_high_released", bad == 0, 1'b1);
        bus.i_scl = 1'b0;
        wait_scl(1'b0, 2);
        chk("t1_scl_fall_2clk", bus.o_scl, 1'b0);
        bad  = 0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) bus.i_scl = ~bus.i_scl;
            tick();
            if (bus.o_scl !== 1'b0) bad++;
            seen |= bus.o_tx_done;
            viol_any |= bus.o_violation;
        end
        chk("t1_scl_ignores_toggles", bad == 0, 1'b1);
        chk("t1_done_5clk", seen, 1'b1);
        chk("t1_no_viol", viol_any, 1'b0);

        // Bit 2: to master, data 0 arriving 8 us late
        bus.i_rx_sda_init_valid = 1'b0;
        bus.i_rx_sda_init       = 1'b0;
        bus.i_rx_done           = 1'b0;
        bus.i_scl               = 1'b0;
        start_bit(1'b1);
        chk("t2_done_cleared", bus.o_tx_done, 1'b0);
        bad = 0;
        repeat (800) begin
            tick();
            if (bus.o_scl !== 1'b0 || bus.o_sda !== 1'b1) bad++;
        end
        chk("t2_stretch_hold", bad == 0, 1'b1);
        bus.i_rx_sda_init_valid = 1'b1;
        prev  = bus.i_f_ref;
        edges = 0;
        early = 1'b0;
        cyc   = 0;
        while (bus.o_scl !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
            if (bus.i_f_ref && !prev) edges++;
            prev = bus.i_f_ref;
            if (bus.o_scl === 1'b1 && edges < 2) early = 1'b1;
        end
        chk("t2_no_rise_before_2_edges", early, 1'b0);
        chk("t2_rise", bus.o_scl, 1'b1);
        chk("t2_rise_prompt", edges <= 3, 1'b1);
        chk("t2_sda0_before_rise", bus.o_sda, 1'b0);
        bus.i_scl = 1'b1;
        bus.i_sda = 1'b0;
        repeat (20) tick();
        bus.i_scl = 1'b0;
        tick();
        bad = 0;
        repeat (3) begin
            tick();
            if (bus.o_tx_done !== 1'b0) bad++;
        end
        chk("t2_wait_rx_done", bad == 0, 1'b1);
        bus.i_rx_done = 1'b1;
        tick();
        chk("t2_done", bus.o_tx_done, 1'b1);
        chk("t2_no_viol_sda0", bus.o_violation, 1'b0);

        // Bit 3: to master, data 1, SDA pulled by someone else
        bus.i_rx_sda_init = 1'b1;
        bus.i_sda         = 1'b1;
        start_bit(1'b1);
        wait_scl(1'b1, 700);
        chk("t3_rise", bus.o_scl, 1'b1);
        bus.i_scl = 1'b1;
        repeat (2) tick();
        bus.i_sda = 1'b0;
        tick();
        bus.i_sda = 1'b1;
        repeat (2) tick();
        chk("t3_no_viol_1clk", bus.o_violation, 1'b0);
        bus.i_sda = 1'b0;
        repeat (3) tick();
        bus.i_sda = 1'b1;
        tick();
        chk("t3_viol", bus.o_violation, 1'b1);
        bus.i_scl = 1'b0;
        repeat (4) tick();
        chk("t3_viol_sticky", bus.o_violation, 1'b1);

        // Bit 4: to slave, stretched rise, mid change to 0
        bus.i_rx_sda_mid_change = 1'b1;
        bus.i_rx_sda_final      = 1'b0;
        bus.i_rx_done           = 1'b0;
        start_bit(1'b0);
        chk("t4_viol_cleared", bus.o_violation, 1'b0);
        wait_scl(1'b1, 700);
        chk("t4_rise", bus.o_scl, 1'b1);
        bad = 0;
        repeat (300) begin
            tick();
            if (bus.o_scl !== 1'b1 || bus.o_sda !== 1'b1) bad++;
        end
        chk("t4_stretch_in_rise", bad == 0, 1'b1);
        bus.i_scl = 1'b1;
        cyc    = 0;
        sda_hi = 1'b1;
        while (bus.o_scl !== 1'b0 && cyc < 600) begin
            tick();
            cyc++;
            if (cyc == 10) sda_hi = bus.o_sda;
        end
        chk("t4_sda_final_in_high", sda_hi, 1'b0);
        chk("t4_high_5us", cyc >= 470 && cyc <= 530, 1'b1);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            bus.i_scl = ~bus.i_scl;
            tick();
            if (bus.o_scl !== 1'b0 || bus.o_tx_done !== 1'b0) bad++;
        end
        chk("t4_end_hold", bad == 0, 1'b1);
        bus.i_rx_done = 1'b1;
        tick();
        chk("t4_done", bus.o_tx_done, 1'b1);

        // Bit 5: reset in the middle of HIGH
        bus.i_rx_sda_mid_change = 1'b0;
        bus.i_rx_done           = 1'b0;
        bus.i_scl               = 1'b0;
        bus.i_sda               = 1'b1;
        start_bit(1'b1);
        wait_scl(1'b1, 700);
        bus.i_scl = 1'b1;
        repeat (2) tick();
        bus.i_sda = 1'b0;
        repeat (3) tick();
        chk("t5_pre_viol", bus.o_violation, 1'b1);
        bus.i_rx_sda_mid_change = 1'b1;
        tick();
        chk("t5_pre_sda", bus.o_sda, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_scl", bus.o_scl, 1'b1);
        chk("t5_rst_sda", bus.o_sda, 1'b1);
        chk("t5_rst_done", bus.o_tx_done, 1'b0);
        chk("t5_rst_viol", bus.o_violation, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_passthru_bittx.md
Name: i2c_passthru_bittx

Overview:
- Per-bit transmitter of the I2C passthru. Counterpart of i2c_passthru_bitrx.
- Drives one bit onto the far-side bus:
  - toward the master, as a clock-stretching slave;
  - toward the slave, as the SCL-generating master.
- The bit value comes from the bitrx status outputs (sda_init, mid_change, sda_final).
- The passthru byte/transaction controller sequences bitrx and bittx once per bit.

Parameters:
- F_REF_T_LOW, 20, i_f_ref rising edges per SCL low time (5.0 us at 4 MHz f_ref).
- WIDTH_F_REF_T_LOW, 5, width of the low/high-phase counter.
- F_REF_T_SU_DAT, 2, f_ref edges from o_sda update to o_scl release.
- WIDTH_F_REF_T_SU_DAT, 2, width of the setup counter.

Ports:
- i_clk, in, 1: system clock.
- i_rst, in, 1: asynchronous active-high reset.
- i_f_ref, in, 1: timing reference, already synchronized to i_clk. Counters advance on its 0->1 edges.
- i_start_tx, in, 1: single-cycle pulse that begins one bit transmission.
- i_tx_is_to_mst, in, 1: sampled on i_start_tx. 1 = transmit to master (slave role); 0 = transmit to slave (master role).
- i_rx_sda_init_valid, in, 1: bitrx has a valid initial SDA value.
- i_rx_sda_init, in, 1: bit value to drive.
- i_rx_sda_mid_change, in, 1: SDA changed while SCL was high on the source side (START/STOP).
- i_rx_sda_final, in, 1: SDA value after a mid change.
- i_rx_done, in, 1: bitrx has finished its bit.
- i_scl, in, 1: far-side SCL line, synchronized.
- i_sda, in, 1: far-side SDA line, synchronized.
- o_scl, out, 1: SCL drive. 0 = pull low, 1 = release.
- o_sda, out, 1: SDA drive. 0 = pull low, 1 = release.
- o_tx_done, out, 1: bit complete.
- o_violation, out, 1: sticky bus error.

Behaviour:
- Reset values: o_scl=1, o_sda=1, o_tx_done=0, o_violation=0, state IDLE, counters 0. Reset mid-bit aborts immediately to these values.
- f_ref edge detect: one register stage. cnt_low/cnt_su increment on a detected edge only.
- IDLE:
  - Outputs hold their previous values.
  - i_start_tx -> LOW. On that same edge: o_scl=0, o_tx_done=0, o_violation=0, mode latched, cnt_low=0.
- LOW:
  - o_scl held 0.
  - Once i_rx_sda_init_valid=1, o_sda <= i_rx_sda_init and cnt_su starts. Until then o_sda=1.
  - Exit only when cnt_low>=F_REF_T_LOW-1 AND cnt_su>=F_REF_T_SU_DAT AND init_valid has been seen -> RISE, o_scl<=1.
  - o_scl must therefore never rise before 4.0 us. With init_valid early it rises by 6.0 us after start.
  - If init_valid arrives late, the low phase simply extends (clock stretching).
- RISE:
  - o_scl=1. Wait for i_scl=1; the far slave may stretch, and there is no timeout.
  - On i_scl=1: cnt_low=0 -> HIGH.
- HIGH:
  - o_sda: if i_rx_sda_mid_change=1, o_sda <= i_rx_sda_final; otherwise hold.
  - To-master mode: stay in HIGH until i_scl=0 is sampled. On that cycle o_scl<=0 (locks the master low) -> END.
  - To-slave mode: after F_REF_T_LOW f_ref edges -> END, o_scl<=0.
  - Violation, to-master mode only: i_sda=0 while o_sda=1 for 2 consecutive clocks -> o_violation<=1. It stays set until the next i_start_tx or reset.
- END:
  - o_scl=0 and o_sda held. Further i_scl toggles are ignored.
  - When i_rx_done=1: o_tx_done<=1 on the next edge -> IDLE. o_scl stays 0 until the next bit's LOW phase.
- Priority: reset > i_start_tx, which restarts from any state > all others.
- o_violation does not alter sequencing.

Decomposition:
- Shared package i2c_passthru_pkg holds the state enum (IDLE, LOW, RISE, HIGH, END) and default timing constants, shared with bitrx.
- One natural sub-module: i2c_passthru_fref_cnt, an f_ref edge-detect plus saturating counter with clear. It is instantiated twice, for low/high timing and for setup.

Test Plan:
- To-master, init_valid=1 and init=1, i_rx_done=1 -> o_scl=0 and o_tx_done=0 for the first 4.0 us. o_sda=1 one clock after start. o_scl=1 by 6.0 us.
- Continue that bit: drive i_scl=1 for 4 us, then 0 -> o_scl=0 within 2 clocks. o_scl stays 0 across 4 i_scl toggles. o_tx_done=1 within 5 clocks. o_violation=0 throughout.
- To-master, init=0 -> o_sda=0 before o_scl rises. Hold i_rx_sda_init_valid=0 for 8 us -> o_scl stays 0 until 2 f_ref edges after valid.
- To-master, sda=1 phase: force i_sda=0 during HIGH for 3 clocks -> o_violation=1. A new i_start_tx clears it.
- To-slave: hold i_scl=0 for 3 us after o_scl=1 (stretch) -> stays in RISE. After i_scl=1, o_scl falls 5.0 us +/- 1 f_ref period later. With i_rx_sda_mid_change=1 and final=0 -> o_sda=0 during high.
- Assert i_rst mid-HIGH -> o_scl=1, o_sda=1, o_tx_done=0, o_violation=0 immediately, without waiting for a clock edge.
